// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory_unit port that the
// arbiter joins together, plus its status flags.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              timeout_err;

    // Arbiter view.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err
    );

    // Requesters plus memory view.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master (fetch / load-store) arbiter in front of memory_unit, 4-phase handshake with watchdog.
// Define ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state_reg, state_next;
    logic              grant_d_reg, grant_d_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              i_ack_reg, i_ack_next;
    logic              d_ack_reg, d_ack_next;
    logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
    logic              timeout_err_reg, timeout_err_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              pick_d;
    logic              expired;
    logic [DATA_W-1:0] rdata_sel;

`ifdef ARB_RR_EN
    logic              last_d_reg, last_d_next;

    // On contention the port not granted last time wins.
    assign pick_d = bus.d_req && (!bus.i_req || !last_d_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_d_reg <= 1'b0;
        else        last_d_reg <= last_d_next;
    end
`else
    assign pick_d = bus.d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            grant_d_reg     <= 1'b0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            i_ack_reg       <= 1'b0;
            d_ack_reg       <= 1'b0;
            i_rdata_reg     <= '0;
            d_rdata_reg     <= '0;
            timeout_err_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            grant_d_reg     <= grant_d_next;
            mem_req_reg     <= mem_req_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            i_ack_reg       <= i_ack_next;
            d_ack_reg       <= d_ack_next;
            i_rdata_reg     <= i_rdata_next;
            d_rdata_reg     <= d_rdata_next;
            timeout_err_reg <= timeout_err_next;
            cnt_reg         <= cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_d_next     = grant_d_reg;
        mem_req_next     = mem_req_reg;
        mem_we_next      = mem_we_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        i_ack_next       = 1'b0;
        d_ack_next       = 1'b0;
        i_rdata_next     = i_rdata_reg;
        d_rdata_next     = d_rdata_reg;
        timeout_err_next = timeout_err_reg;
        cnt_next         = cnt_reg;
        expired          = 1'b0;
        rdata_sel        = '0;
`ifdef ARB_RR_EN
        last_d_next      = last_d_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.d_req || bus.i_req) begin
                    state_next   = REQ;
                    grant_d_next = pick_d;
                    mem_req_next = 1'b1;
                    cnt_next     = '0;
`ifdef ARB_RR_EN
                    last_d_next  = pick_d;
`endif
                    if (pick_d) begin
                        mem_we_next    = bus.d_we;
                        mem_addr_next  = bus.d_addr;
                        mem_wdata_next = bus.d_wdata;
                    end else begin
                        mem_we_next    = 1'b0;
                        mem_addr_next  = bus.i_addr;
                        mem_wdata_next = '0;
                    end
                end
            end

            REQ: begin
                expired = (TIMEOUT_CYCLES > 0) && (cnt_reg == CNT_LAST);
                if (bus.mem_ack || expired) begin
                    // A real ack always beats a simultaneous watchdog expiry.
                    rdata_sel    = bus.mem_ack ? bus.mem_rdata : '0;
                    mem_req_next = 1'b0;
                    state_next   = DRAIN;
                    if (!bus.mem_ack) timeout_err_next = 1'b1;
                    if (grant_d_reg) begin
                        d_ack_next = 1'b1;
                        if (!mem_we_reg) d_rdata_next = rdata_sel;
                    end else begin
                        i_ack_next   = 1'b1;
                        i_rdata_next = rdata_sel;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DRAIN: begin
                if (!bus.mem_ack) state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.i_ack       = i_ack_reg;
    assign bus.i_rdata     = i_rdata_reg;
    assign bus.d_ack       = d_ack_reg;
    assign bus.d_rdata     = d_rdata_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, D write, I read, contention,
// watchdog expiry and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_mem_req_rise"}, 64'(bus.mem_req), 64'd1);
    endtask

    // Called just after mem_req rose; memory acks so that the arbiter samples
    // mem_ack lat cycles after the rise, then the requester releases its req.
    task automatic serve(input string tag, input int lat, input logic [31:0] mem_data,
                         input bit is_d, input logic [31:0] exp_rdata);
        for (int k = 1; k < lat; k++) step();
        check({tag, "_req_held"}, {62'd0, bus.mem_req, bus.busy}, 64'h3);
        check({tag, "_no_early_ack"}, {62'd0, bus.i_ack, bus.d_ack}, 64'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_data;
        step();
        check({tag, "_ack"}, {62'd0, bus.i_ack, bus.d_ack}, is_d ? 64'h1 : 64'h2);
        check({tag, "_req_drop"}, 64'(bus.mem_req), 64'd0);
        check({tag, "_rdata"}, is_d ? 64'(bus.d_rdata) : 64'(bus.i_rdata), 64'(exp_rdata));
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        step();
        check({tag, "_ack_pulse_end"}, {61'd0, bus.i_ack, bus.d_ack, bus.busy}, 64'h0);
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
        $display("[TB] txn %s port=%s lat=%0d rdata=0x%08h", tag, is_d ? "D" : "I", lat,
                 is_d ? bus.d_rdata : bus.i_rdata);
    endtask

    initial begin
        int n;
        bit first_d;

        // Reset with random inputs.
        for (int c = 0; c < 10; c++) begin
            bus.i_req = 1'($urandom); bus.i_addr = $urandom;
            bus.d_req = 1'($urandom); bus.d_we = 1'($urandom);
            bus.d_addr = $urandom; bus.d_wdata = $urandom;
            bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom;
            step();
            check("reset_outputs_zero",
                  {54'd0, bus.i_ack, bus.d_ack, bus.mem_req, bus.mem_we, bus.busy,
                   bus.timeout_err, |bus.i_rdata, |bus.d_rdata, |bus.mem_addr, |bus.mem_wdata},
                  64'd0);
        end
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
        rst_n = 1'b1;
        step(); step();
        check("post_reset_idle", {62'd0, bus.busy, bus.mem_req}, 64'd0);

        // D write, memory acks 5 cycles after mem_req rises.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0; bus.d_wdata = 32'h12345678;
        check("dwr_no_comb_grant", 64'(bus.mem_req), 64'd0);
        step();
        check("dwr_grant_latency", 64'(bus.mem_req), 64'd1);
        check("dwr_mem_we", 64'(bus.mem_we), 64'd1);
        check("dwr_mem_addr", 64'(bus.mem_addr), 64'h0);
        check("dwr_mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
        serve("dwr", 5, 32'hDEADBEEF, 1'b1, 32'h0);
        step();
        check("dwr_no_regrant", {62'd0, bus.mem_req, bus.busy}, 64'd0);

        // I read.
        bus.i_req = 1; bus.i_addr = 32'h4;
        step();
        check("ird_mem_addr", 64'(bus.mem_addr), 64'h4);
        check("ird_mem_we", 64'(bus.mem_we), 64'd0);
        check("ird_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        serve("ird", 3, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);
        step(); step();
        check("ird_rdata_held", 64'(bus.i_rdata), 64'hCAFEF00D);
        check("ird_d_rdata_kept", 64'(bus.d_rdata), 64'h0);

        // Simultaneous requests after an I grant: D first in both modes.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        bus.i_req = 1; bus.i_addr = 32'h200;
        step();
        check("both1_first_addr", 64'(bus.mem_addr), 64'h100);
        serve("both1_d", 2, 32'h11112222, 1'b1, 32'h11112222);
        wait_mem_req("both1_i");
        check("both1_second_addr", 64'(bus.mem_addr), 64'h200);
        serve("both1_i", 1, 32'h33334444, 1'b0, 32'h33334444);
        step();

        // D-only read, then contention: round-robin favours I, fixed favours D.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        step();
        serve("dsingle", 2, 32'h55556666, 1'b1, 32'h55556666);
        step();
`ifdef ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        bus.d_req = 1; bus.d_addr = 32'h100;
        bus.i_req = 1; bus.i_addr = 32'h200;
        step();
        check("both2_first_addr", 64'(bus.mem_addr), first_d ? 64'h100 : 64'h200);
        serve("both2_first", 2, 32'h77778888, first_d, 32'h77778888);
        wait_mem_req("both2_second");
        check("both2_second_addr", 64'(bus.mem_addr), first_d ? 64'h200 : 64'h100);
        serve("both2_second", 2, 32'h9999AAAA, !first_d, 32'h9999AAAA);
        step();

        // Watchdog: memory never acks a D read.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h8; bus.mem_rdata = 32'hFFFFFFFF;
        wait_mem_req("tmo");
        n = 0;
        while (bus.d_ack !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("tmo_req_cycles", 64'(n), 64'(TO));
        check("tmo_err_set", 64'(bus.timeout_err), 64'd1);
        check("tmo_d_rdata_zero", 64'(bus.d_rdata), 64'h0);
        check("tmo_req_drop", 64'(bus.mem_req), 64'd0);
        step();
        bus.d_req = 0;
        $display("[TB] txn tmo port=D cycles=%0d timeout_err=%0b", n, bus.timeout_err);
        step();
        bus.i_req = 1; bus.i_addr = 32'hC;
        step();
        serve("after_tmo", 2, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE);
        check("tmo_err_sticky", 64'(bus.timeout_err), 64'd1);
        step();

        // Asynchronous reset while in REQ.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        wait_mem_req("rst");
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", {61'd0, bus.mem_req, bus.busy, bus.timeout_err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_mem_req("rst_reissue");
        check("rst_reissue_addr", 64'(bus.mem_addr), 64'h40);
        // Ack on the same edge the watchdog would expire: normal completion.
        serve("ack_at_expiry", TO, 32'h5A5A5A5A, 1'b1, 32'h5A5A5A5A);
        check("ack_at_expiry_no_err", 64'(bus.timeout_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
